// File: rtl/valu_pkg.sv
// Shared definitions for the vector ALU slice.
// Holds the opcode encodings, the vector width, the legal SEW widths and
// the arithmetic kind that each opcode resolves to.
package valu_pkg;

  localparam int VLEN = 512;

  localparam logic [7:0] OP_VADD_VV  = 8'h00;
  localparam logic [7:0] OP_VMUL_VV  = 8'h01;
  localparam logic [7:0] OP_VDOT_VV  = 8'h02;
  localparam logic [7:0] OP_VADDVARP = 8'h03;
  localparam logic [7:0] OP_VMULVARP = 8'h04;
  localparam logic [7:0] OP_VDOTVARP = 8'h05;

  localparam logic [9:0] SEW_8  = 10'd8;
  localparam logic [9:0] SEW_16 = 10'd16;
  localparam logic [9:0] SEW_32 = 10'd32;
  localparam logic [9:0] SEW_64 = 10'd64;

  typedef enum logic [1:0] {
    K_ADD = 2'd0,
    K_MUL = 2'd1,
    K_MAC = 2'd2
  } kind_e;

  // Both opcode families share the same add/mul/mac ordering.
  function automatic kind_e op_kind(input logic [7:0] op);
    case (op)
      OP_VADD_VV, OP_VADDVARP: return K_ADD;
      OP_VMUL_VV, OP_VMULVARP: return K_MUL;
      default:                 return K_MAC;
    endcase
  endfunction

endpackage

// File: rtl/valu_lane_mac.sv
// One unsigned add/mul/mac lane, up to 64 bits wide.
// Ports:
//   kind  - arithmetic selection (add, mul, mac)
//   width - active element width in bits (1..64); result is masked to it
//   a,b,c - zero-extended element operands (c used only for mac)
//   r     - result, modulo 2^width, upper bits forced to 0
module valu_lane_mac
  import valu_pkg::*;
(
  input  kind_e       kind,
  input  logic [6:0]  width,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [63:0] c,
  output logic [63:0] r
);

  logic [63:0] mask;
  logic [63:0] full;

  always_comb begin
    mask = (width >= 7'd64) ? '1 : ((64'd1 << width) - 64'd1);
    case (kind)
      K_ADD:   full = a + b;
      K_MUL:   full = a * b;
      default: full = a * b + c;
    endcase
    r = full & mask;
  end

endmodule

// File: rtl/alu_block.sv
// Two-stage pipelined vector ALU: element-wise add, mul and mac on
// VLEN-bit operands, with SEW-selected (8/16/32/64) or vap-selected (1..8)
// element widths. Illegal opcode/width combinations produce a zero result.
// Ports:
//   clk, resetn        - clock, async active-low reset
//   micro_exec_instr   - opcode
//   SEW, vap           - element width for .vv and varp opcodes
//   opA, opB, opC      - operands (opC is the dot-product accumulator)
//   alu_out, alu_done  - registered result and its valid bit
module alu_block
  import valu_pkg::*;
#(
  parameter int VLEN = valu_pkg::VLEN
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [7:0]      micro_exec_instr,
  input  logic [9:0]      SEW,
  input  logic [3:0]      vap,
  input  logic [VLEN-1:0] opA,
  input  logic [VLEN-1:0] opB,
  input  logic [VLEN-1:0] opC,
  output logic [VLEN-1:0] alu_out,
  output logic            alu_done
);

  logic [7:0]      op_d,  op_q;
  logic [9:0]      sew_d, sew_q;
  logic [3:0]      vap_d, vap_q;
  logic [VLEN-1:0] a_d, a_q, b_d, b_q, c_d, c_q;
  logic            vld_d, vld_q;
  logic [VLEN-1:0] out_d, out_q;
  logic            done_d, done_q;

  kind_e           kind_s1;
  logic [VLEN-1:0] sew_res  [4];
  logic [VLEN-1:0] varp_res [8];

  always_comb begin
    op_d   = micro_exec_instr;
    sew_d  = SEW;
    vap_d  = vap;
    a_d    = opA;
    b_d    = opB;
    c_d    = opC;
    vld_d  = 1'b1;
    done_d = vld_q;
  end

  assign kind_s1 = op_kind(op_q);

  // SEW path: one lane instance per element for each legal width.
  for (genvar k = 0; k < 4; k++) begin : g_sew
    localparam int W = 8 << k;
    localparam int N = VLEN / W;
    logic [63:0]     lr [N];
    logic [VLEN-1:0] res;

    for (genvar i = 0; i < N; i++) begin : g_lane
      valu_lane_mac u_lane (
        .kind  (kind_s1),
        .width (7'(W)),
        .a     (64'(a_q[i*W +: W])),
        .b     (64'(b_q[i*W +: W])),
        .c     (64'(c_q[i*W +: W])),
        .r     (lr[i])
      );
    end

    // Lane outputs are already masked, so OR-ing them in place is exact.
    always_comb begin
      res = '0;
      for (int i = 0; i < N; i++) begin
        res = res | (VLEN'(lr[i]) << (i * W));
      end
    end

    assign sew_res[k] = res;
  end

  // varp path: one packed result per legal vap; leftover top bits stay 0.
  for (genvar v = 1; v <= 8; v++) begin : g_varp
    localparam int N = VLEN / v;
    logic [VLEN-1:0] res;
    logic [v-1:0]    ea, eb, ec, er;

    always_comb begin
      res = '0;
      ea  = '0;
      eb  = '0;
      ec  = '0;
      er  = '0;
      for (int i = 0; i < N; i++) begin
        ea = a_q[i*v +: v];
        eb = b_q[i*v +: v];
        ec = c_q[i*v +: v];
        case (kind_s1)
          K_ADD:   er = ea + eb;
          K_MUL:   er = ea * eb;
          default: er = ea * eb + ec;
        endcase
        res[i*v +: v] = er;
      end
    end

    assign varp_res[v-1] = res;
  end

  always_comb begin
    out_d = '0;
    case (op_q)
      OP_VADD_VV, OP_VMUL_VV, OP_VDOT_VV: begin
        case (sew_q)
          SEW_8:   out_d = sew_res[0];
          SEW_16:  out_d = sew_res[1];
          SEW_32:  out_d = sew_res[2];
          SEW_64:  out_d = sew_res[3];
          default: out_d = '0;
        endcase
      end
      OP_VADDVARP, OP_VMULVARP, OP_VDOTVARP: begin
        if (vap_q >= 4'd1 && vap_q <= 4'd8) out_d = varp_res[3'(vap_q - 4'd1)];
      end
      default: out_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q   <= '0;
      sew_q  <= '0;
      vap_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      vld_q  <= 1'b0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      op_q   <= op_d;
      sew_q  <= sew_d;
      vap_q  <= vap_d;
      a_q    <= a_d;
      b_q    <= b_d;
      c_q    <= c_d;
      vld_q  <= vld_d;
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  assign alu_out  = out_q;
  assign alu_done = done_q;

endmodule

// File: tb/tb_alu_block.sv
module tb_alu_block;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic [7:0]   micro_exec_instr = '0;
  logic [9:0]   SEW = '0;
  logic [3:0]   vap = '0;
  logic [511:0] opA = '0, opB = '0, opC = '0;
  logic [511:0] alu_out;
  logic         alu_done;

  int total = 0;
  int bad = 0;
  logic [511:0] expq[$];

  alu_block #(.VLEN(512)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .micro_exec_instr (micro_exec_instr),
    .SEW              (SEW),
    .vap              (vap),
    .opA              (opA),
    .opB              (opB),
    .opC              (opC),
    .alu_out          (alu_out),
    .alu_done         (alu_done)
  );

  always #5 clk = ~clk;

  // Reference: split into floor(512/W) elements, compute with 64-bit
  // arithmetic, keep low W bits, zero everything else.
  function automatic logic [511:0] model(input logic [7:0] op, input logic [9:0] sew,
                                         input logic [3:0] vap_i, input logic [511:0] a,
                                         input logic [511:0] b, input logic [511:0] c);
    int w;
    logic [511:0] res;
    logic [63:0] m, ea, eb, ec, r;
    w = 0;
    res = '0;
    if (op <= 8'd2) begin
      if (sew == 10'd8 || sew == 10'd16 || sew == 10'd32 || sew == 10'd64) w = int'(sew);
    end else if (op <= 8'd5) begin
      if (vap_i >= 4'd1 && vap_i <= 4'd8) w = int'(vap_i);
    end
    if (w == 0) return '0;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    for (int i = 0; i < 512 / w; i++) begin
      ea = 64'(a >> (i * w)) & m;
      eb = 64'(b >> (i * w)) & m;
      ec = 64'(c >> (i * w)) & m;
      if (op == 8'd0 || op == 8'd3)      r = ea + eb;
      else if (op == 8'd1 || op == 8'd4) r = ea * eb;
      else                               r = ea * eb + ec;
      res = res | (512'(r & m) << (i * w));
    end
    return res;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive(input logic [7:0] op, input logic [9:0] sew, input logic [3:0] v,
                       input logic [511:0] a, input logic [511:0] b, input logic [511:0] c);
    micro_exec_instr = op;
    SEW = sew;
    vap = v;
    opA = a;
    opB = b;
    opC = c;
    expq.push_back(model(op, sew, v, a, b, c));
  endtask

  task automatic test_reset();
    #2 resetn = 1'b0;
    #1;
    total++;
    if (alu_out !== '0 || alu_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_assert out=%h done=%b want 0/0", alu_out, alu_done);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    total++;
    if (alu_done !== 1'b0 || alu_out !== '0) begin
      bad++;
      $display("FAIL reset_first_edge done=%b out=%h want 0/0", alu_done, alu_out);
    end
    @(posedge clk); #1;
    total++;
    if (alu_done !== 1'b1) begin
      bad++;
      $display("FAIL reset_second_edge done=%b want 1", alu_done);
    end
  endtask

  task automatic test_directed();
    logic [7:0]   t_op  [11];
    logic [9:0]   t_sew [11];
    logic [3:0]   t_vap [11];
    logic [511:0] t_a [11], t_b [11], t_c [11], t_exp [11];
    for (int i = 0; i < 11; i++) begin
      t_sew[i] = 10'd32; t_vap[i] = 4'd8;
      t_a[i] = rand512(); t_b[i] = rand512(); t_c[i] = rand512();
    end
    t_op[0] = 8'h03; t_a[0] = 512'h0807060504030201; t_b[0] = t_a[0]; t_exp[0] = 512'h100E0C0A08060402;
    t_op[1] = 8'h04; t_a[1] = 512'h0F0E0D0C0B0A09; t_b[1] = t_a[1]; t_exp[1] = 512'hE1C4A990796451;
    t_op[2] = 8'h03; t_a[2] = 512'hFF; t_b[2] = 512'h01; t_exp[2] = '0;
    t_op[3] = 8'h03; t_vap[3] = 4'd0; t_exp[3] = '0;
    t_op[4] = 8'h00; t_sew[4] = 10'd12; t_exp[4] = '0;
    t_op[5] = 8'h01; t_a[5] = 512'h1111; t_b[5] = t_a[5]; t_exp[5] = 512'h01234321;
    t_op[6] = 8'h02; t_a[6] = 512'h1111; t_b[6] = t_a[6]; t_c[6] = {16{32'h22221111}};
    t_exp[6] = {{15{32'h22221111}}, 32'h23455432};
    t_op[7] = 8'h07; t_exp[7] = '0;
    t_op[8] = 8'h00; t_sew[8] = 10'd64; t_a[8] = {8{64'hFFFF_FFFF_FFFF_FFFF}};
    t_b[8] = {8{64'd2}}; t_exp[8] = {8{64'd1}};
    t_op[9] = 8'h03; t_vap[9] = 4'd3; t_a[9] = {512{1'b1}}; t_b[9] = '0;
    t_exp[9] = {2'b00, {510{1'b1}}};
    t_op[10] = 8'h04; t_vap[10] = 4'd9; t_exp[10] = '0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      drive(t_op[i], t_sew[i], t_vap[i], t_a[i], t_b[i], t_c[i]);
      @(posedge clk);
      @(posedge clk); #1;
      total++;
      if (alu_out !== t_exp[i] || alu_done !== 1'b1) begin
        bad++;
        $display("FAIL directed_%0d out=%h done=%b want=%h", i, alu_out, alu_done, t_exp[i]);
      end
    end
    expq.delete();
  endtask

  task automatic test_random(input int cycles);
    logic [9:0] sew_tab [8];
    logic [511:0] e;
    sew_tab = '{10'd8, 10'd16, 10'd32, 10'd64, 10'd12, 10'd0, 10'd64, 10'd8};
    expq.delete();
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (expq.size() == 2) begin
        e = expq.pop_front();
        total++;
        if (alu_out !== e || alu_done !== 1'b1) begin
          bad++;
          $display("FAIL random cyc=%0d out=%h done=%b want=%h", n, alu_out, alu_done, e);
        end
      end
      drive(8'($urandom_range(0, 7)), sew_tab[$urandom_range(0, 7)],
            4'($urandom_range(0, 9)), rand512(), rand512(), rand512());
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] sew_tab [4];
    logic [511:0] e;
    sew_tab = '{10'd8, 10'd16, 10'd32, 10'd64};
    expq.delete();
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (expq.size() == 2) begin
        e = expq.pop_front();
        total++;
        if (alu_out !== e || alu_done !== 1'b1) begin
          bad++;
          $display("FAIL back_to_back cyc=%0d out=%h want=%h", n, alu_out, e);
        end
      end
      drive(8'(n % 6), sew_tab[$urandom_range(0, 3)], 4'($urandom_range(1, 8)),
            rand512(), rand512(), rand512());
    end
  endtask

  task automatic test_hold();
    logic [511:0] a, b, c, e;
    logic [3:0] v;
    a = rand512(); b = rand512(); c = rand512(); v = 4'($urandom_range(1, 8));
    expq.delete();
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (expq.size() == 2) begin
        e = expq.pop_front();
        total++;
        if (alu_out !== e || alu_done !== 1'b1) begin
          bad++;
          $display("FAIL hold cyc=%0d out=%h want=%h", n, alu_out, e);
        end
      end
      drive(8'h05, 10'd16, v, a, b, c);
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] e;
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    total++;
    if (alu_out !== '0 || alu_done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_async out=%h done=%b want 0/0", alu_out, alu_done);
    end
    @(posedge clk); #1;
    total++;
    if (alu_out !== '0 || alu_done !== 1'b0) begin
      bad++;
      $display("FAIL midreset_held out=%h done=%b want 0/0", alu_out, alu_done);
    end
    @(negedge clk);
    expq.delete();
    drive(8'h02, 10'd8, 4'd0, rand512(), rand512(), rand512());
    e = expq.pop_front();
    resetn = 1'b1;
    @(posedge clk); #1;
    total++;
    if (alu_done !== 1'b0 || alu_out !== '0) begin
      bad++;
      $display("FAIL midreset_refill1 done=%b out=%h want 0/0", alu_done, alu_out);
    end
    @(posedge clk); #1;
    total++;
    if (alu_done !== 1'b1 || alu_out !== e) begin
      bad++;
      $display("FAIL midreset_refill2 done=%b out=%h want=%h", alu_done, alu_out, e);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(200);
    test_back_to_back();
    test_hold();
    test_random(20);
    test_reset_mid();
    test_random(100);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
